// File: rtl/vga_sync_decoder.sv
// Receive-side sync decoder for the 1600x1200@60 VGA driver: acquires HSYNC/VSYNC
// timing, recovers pixel coordinates and reports timing violations once locked.
module vga_sync_decoder #(
   parameter int unsigned H_TOTAL      = 2160,
   parameter int unsigned H_SYNC_START = 64,
   parameter int unsigned H_SYNC_LEN   = 192,
   parameter int unsigned H_VIS_START  = 560,
   parameter int unsigned H_VIS        = 1600,
   parameter int unsigned V_TOTAL      = 1250,
   parameter int unsigned V_SYNC_START = 1,
   parameter int unsigned V_SYNC_LEN   = 3,
   parameter int unsigned V_VIS_START  = 50,
   parameter int unsigned V_VIS        = 1200,
   parameter int unsigned LOCK_LINES   = 4
) (
   input  logic        clock_162,
   input  logic        rst,
   input  logic        HSYNC,
   input  logic        VSYNC,
   input  logic [3:0]  RED,
   input  logic [3:0]  GREEN,
   input  logic [3:0]  BLUE,
   output logic        pix_valid,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic [11:0] pix_rgb,
   output logic        frame_done,
   output logic        locked,
   output logic        h_err,
   output logic        v_err,
   output logic [15:0] frame_count
);

   localparam logic [11:0] C_H_TOT    = 12'(H_TOTAL);
   localparam logic [11:0] C_H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] C_HS_START = 12'(H_SYNC_START);
   localparam logic [11:0] C_HS_END   = 12'(H_SYNC_START + H_SYNC_LEN);
   localparam logic [11:0] C_HS_LEN   = 12'(H_SYNC_LEN);
   localparam logic [11:0] C_HV_FIRST = 12'(H_VIS_START);
   localparam logic [11:0] C_HV_LAST  = 12'(H_VIS_START + H_VIS - 1);
   localparam logic [10:0] C_V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] C_VS_START = 11'(V_SYNC_START);
   localparam logic [10:0] C_VS_END   = 11'(V_SYNC_START + V_SYNC_LEN);
   localparam logic [10:0] C_VV_FIRST = 11'(V_VIS_START);
   localparam logic [10:0] C_VV_LAST  = 11'(V_VIS_START + V_VIS - 1);
   localparam logic [7:0]  C_LOCK     = 8'(LOCK_LINES);

   typedef enum logic [1:0] {S_SEARCH, S_H_TRACK, S_V_WAIT, S_LOCKED} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_hs_prev, r_vs_prev;
   logic        w_h_fall, w_h_rise, w_v_fall, w_v_rise;
   logic [11:0] r_h_cnt, w_h_pos;
   logic [10:0] r_v_cnt;
   logic [11:0] r_period, w_period;
   logic [11:0] r_low, r_width;
   logic [7:0]  r_match;
   logic        w_line_ok, w_h_fail, w_v_fail;
   logic        w_vis, w_frame_last, w_h_err, w_v_err;
   logic [10:0] w_x, w_y;

   logic        r_pix_valid, r_frame_done, r_locked, r_h_err, r_v_err;
   logic [10:0] r_pix_x, r_pix_y;
   logic [11:0] r_pix_rgb;
   logic [15:0] r_frame_count;

   assign w_h_fall = ~HSYNC & r_hs_prev;
   assign w_h_rise = HSYNC & ~r_hs_prev;
   assign w_v_fall = ~VSYNC & r_vs_prev;
   assign w_v_rise = VSYNC & ~r_vs_prev;

   // Once tracking, every HSYNC fall re-anchors the column; checks use the prediction r_h_cnt.
   assign w_h_pos   = (r_state != S_SEARCH && w_h_fall) ? C_HS_START : r_h_cnt;
   assign w_period  = r_period + 12'd1;
   assign w_line_ok = (w_period == C_H_TOT) && (r_width == C_HS_LEN);

   assign w_h_fail = (w_h_fall != (r_h_cnt == C_HS_START)) ||
                     (w_h_rise && (r_h_cnt != C_HS_END));
   assign w_v_fail = (w_v_fall != ((r_v_cnt == C_VS_START) && (r_h_cnt == '0))) ||
                     (w_v_rise && !((r_v_cnt == C_VS_END) && (r_h_cnt == '0)));

   always_ff @(posedge clock_162) begin
      if (rst) r_state <= S_SEARCH;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_SEARCH:  if (w_h_fall) w_state_nxt = S_H_TRACK;
         S_H_TRACK: begin
            if (w_h_fall) begin
               if (w_line_ok && (r_match + 8'd1 == C_LOCK)) w_state_nxt = S_V_WAIT;
            end else if (w_period > C_H_TOT) begin
               w_state_nxt = S_SEARCH;
            end
         end
         S_V_WAIT: begin
            if (w_h_fail || (w_v_fall && w_h_pos != '0)) w_state_nxt = S_SEARCH;
            else if (w_v_fall)                           w_state_nxt = S_LOCKED;
         end
         S_LOCKED:  if (w_h_fail || w_v_fail) w_state_nxt = S_SEARCH;
         default:   w_state_nxt = S_SEARCH;
      endcase
   end

   // Pixels are qualified only when the lock survives this cycle, so an error cycle emits none.
   always_comb begin
      w_h_err      = (r_state == S_LOCKED) && w_h_fail;
      w_v_err      = (r_state == S_LOCKED) && w_v_fail;
      w_vis        = (r_state == S_LOCKED) && (w_state_nxt == S_LOCKED) &&
                     (w_h_pos >= C_HV_FIRST) && (w_h_pos <= C_HV_LAST) &&
                     (r_v_cnt >= C_VV_FIRST) && (r_v_cnt <= C_VV_LAST);
      w_frame_last = w_vis && (w_h_pos == C_HV_LAST) && (r_v_cnt == C_VV_LAST);
      w_x          = 11'(w_h_pos - C_HV_FIRST);
      w_y          = r_v_cnt - C_VV_FIRST;
   end

   always_ff @(posedge clock_162) begin
      if (rst) begin
         r_hs_prev     <= 1'b0;
         r_vs_prev     <= 1'b0;
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_period      <= '0;
         r_low         <= '0;
         r_width       <= '0;
         r_match       <= '0;
         r_pix_valid   <= 1'b0;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_pix_rgb     <= '0;
         r_frame_done  <= 1'b0;
         r_locked      <= 1'b0;
         r_h_err       <= 1'b0;
         r_v_err       <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_hs_prev <= HSYNC;
         r_vs_prev <= VSYNC;
         r_h_cnt   <= (w_h_pos == C_H_LAST) ? '0 : w_h_pos + 12'd1;

         if (r_state == S_V_WAIT && w_state_nxt == S_LOCKED)
            r_v_cnt <= C_VS_START;
         else if (w_h_pos == C_H_LAST)
            r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 11'd1;

         if (w_h_fall)        r_period <= '0;
         else if (~&r_period) r_period <= w_period;

         if (w_h_fall)                  r_low <= 12'd1;
         else if (!HSYNC && ~&r_low)    r_low <= r_low + 12'd1;
         if (w_h_rise)                  r_width <= r_low;

         if (r_state == S_SEARCH)
            r_match <= '0;
         else if (r_state == S_H_TRACK && w_h_fall)
            r_match <= w_line_ok ? r_match + 8'd1 : '0;

         r_pix_valid  <= w_vis;
         r_pix_x      <= w_vis ? w_x : '0;
         r_pix_y      <= w_vis ? w_y : '0;
         r_pix_rgb    <= w_vis ? {RED, GREEN, BLUE} : '0;
         r_frame_done <= w_frame_last;
         r_locked     <= (w_state_nxt == S_LOCKED);
         r_h_err      <= w_h_err;
         r_v_err      <= w_v_err;

         if (w_state_nxt == S_SEARCH) r_frame_count <= '0;
         else if (w_frame_last)       r_frame_count <= r_frame_count + 16'd1;
      end
   end

   assign pix_valid   = r_pix_valid;
   assign pix_x       = r_pix_x;
   assign pix_y       = r_pix_y;
   assign pix_rgb     = r_pix_rgb;
   assign frame_done  = r_frame_done;
   assign locked      = r_locked;
   assign h_err       = r_h_err;
   assign v_err       = r_v_err;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster driven by a behavioural
// VGA source with fault injection (HSYNC glitch, VSYNC hold, odd line length).
module tb_vga_sync_decoder;
   localparam int HT = 40, HSS = 4, HSL = 6, HVS = 16, HV = 20;
   localparam int VT = 20, VSS = 1, VSL = 3, VVS = 6, VV = 10, LL = 4;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0, rst = 1'b1, HSYNC = 1'b1, VSYNC = 1'b1;
   logic [3:0]  RED = '0, GREEN = '0, BLUE = '0;
   logic        pix_valid, frame_done, locked, h_err, v_err;
   logic [10:0] pix_x, pix_y;
   logic [11:0] pix_rgb;
   logic [15:0] frame_count;

   vga_sync_decoder #(
      .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .H_VIS_START(HVS), .H_VIS(HV),
      .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .V_VIS_START(VVS), .V_VIS(VV),
      .LOCK_LINES(LL)
   ) dut (
      .clock_162(clk), .rst(rst), .HSYNC(HSYNC), .VSYNC(VSYNC),
      .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_done(frame_done), .locked(locked), .h_err(h_err), .v_err(v_err),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          col;
      int          row;
      logic [11:0] rgb;
      logic        v;
      logic [10:0] x;
      logic [10:0] y;
      logic [11:0] orgb;
      logic        done;
   } vec_t;

   vec_t        vecs[12];
   int          checks = 0, failures = 0;
   int          cur_col = 0, cur_row = 0, drv_htot = HT;
   bit          drv_hold = 1'b1, vs_hold = 1'b0;
   int          g_col = -1, g_row = -1, ov_col = -1, ov_row = -1;
   logic [11:0] ov_rgb = '0;
   int          cnt_valid = 0, cnt_done = 0, cnt_herr = 0, cnt_verr = 0, cnt_locked = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      logic [11:0] c;
      HSYNC = !((cur_col >= HSS && cur_col < HSS + HSL) || (cur_col == g_col && cur_row == g_row));
      VSYNC = vs_hold || !(cur_row >= VSS && cur_row < VSS + VSL);
      c = (cur_col == ov_col && cur_row == ov_row) ? ov_rgb : 12'((cur_col * 37 + cur_row * 101) % 4096);
      {RED, GREEN, BLUE} = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (pix_valid)  cnt_valid++;
      if (frame_done) cnt_done++;
      if (h_err)      cnt_herr++;
      if (v_err)      cnt_verr++;
      if (locked)     cnt_locked++;
      if (!drv_hold) begin
         cur_col++;
         if (cur_col >= drv_htot) begin
            cur_col = 0;
            cur_row++;
            if (cur_row >= VT) cur_row = 0;
         end
      end
      drive();
   endtask

   task automatic clr_counts();
      cnt_valid = 0; cnt_done = 0; cnt_herr = 0; cnt_verr = 0; cnt_locked = 0;
   endtask

   // Leaves the driver presenting (col,row) on the inputs, edge not yet taken.
   task automatic goto(input int col, input int row);
      int n;
      n = 0;
      drive();
      while (!(cur_col == col && cur_row == row) && n < 2 * FRAME + HT) begin
         tick();
         n++;
      end
      chk("goto_reached", (cur_col == col && cur_row == row), 1);
   endtask

   task automatic wait_lock(input string name);
      int n;
      n = 0;
      while (!locked && n < 2 * FRAME) begin
         tick();
         n++;
      end
      chk(name, locked, 1);
   endtask

   initial begin
      vecs[0]  = '{15,  5, 12'h123, 1'b0, 11'd0,  11'd0, 12'h000, 1'b0};
      vecs[1]  = '{16,  6, 12'hF0F, 1'b1, 11'd0,  11'd0, 12'hF0F, 1'b0};
      vecs[2]  = '{15,  7, 12'h111, 1'b0, 11'd0,  11'd0, 12'h000, 1'b0};
      vecs[3]  = '{35,  7, 12'h222, 1'b1, 11'd19, 11'd1, 12'h222, 1'b0};
      vecs[4]  = '{36,  7, 12'h333, 1'b0, 11'd0,  11'd0, 12'h000, 1'b0};
      vecs[5]  = '{ 0,  8, 12'h444, 1'b0, 11'd0,  11'd0, 12'h000, 1'b0};
      vecs[6]  = '{20, 10, 12'hABC, 1'b1, 11'd4,  11'd4, 12'hABC, 1'b0};
      vecs[7]  = '{16, 15, 12'h555, 1'b1, 11'd0,  11'd9, 12'h555, 1'b0};
      vecs[8]  = '{34, 15, 12'h666, 1'b1, 11'd18, 11'd9, 12'h666, 1'b0};
      vecs[9]  = '{35, 15, 12'h777, 1'b1, 11'd19, 11'd9, 12'h777, 1'b1};
      vecs[10] = '{36, 15, 12'h999, 1'b0, 11'd0,  11'd0, 12'h000, 1'b0};
      vecs[11] = '{16, 16, 12'h888, 1'b0, 11'd0,  11'd0, 12'h000, 1'b0};

      drive();
      repeat (10) tick();
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_x", pix_x, 0);
      chk("rst_pix_y", pix_y, 0);
      chk("rst_pix_rgb", pix_rgb, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_locked", locked, 0);
      chk("rst_h_err", h_err, 0);
      chk("rst_v_err", v_err, 0);
      chk("rst_frame_count", frame_count, 0);

      rst = 1'b0;
      drv_hold = 1'b0;
      wait_lock("initial_lock");
      clr_counts();

      for (int i = 0; i < 12; i++) begin
         ov_col = vecs[i].col;
         ov_row = vecs[i].row;
         ov_rgb = vecs[i].rgb;
         goto(vecs[i].col, vecs[i].row);
         tick();
         chk($sformatf("vec%0d_valid", i), pix_valid, vecs[i].v);
         chk($sformatf("vec%0d_x", i), pix_x, vecs[i].x);
         chk($sformatf("vec%0d_y", i), pix_y, vecs[i].y);
         chk($sformatf("vec%0d_rgb", i), pix_rgb, vecs[i].orgb);
         chk($sformatf("vec%0d_done", i), frame_done, vecs[i].done);
      end
      ov_col = -1;
      chk("fc_first_frame", frame_count, 1);

      cnt_valid = 0;
      cnt_done  = 0;
      repeat (FRAME) tick();
      chk("valid_per_frame", cnt_valid, HV * VV);
      chk("done_per_frame", cnt_done, 1);
      chk("fc_second_frame", frame_count, 2);
      repeat (FRAME) tick();
      chk("fc_third_frame", frame_count, 3);
      chk("no_h_err_3_frames", cnt_herr, 0);
      chk("no_v_err_3_frames", cnt_verr, 0);
      chk("still_locked", locked, 1);

      // Single-clock HSYNC glitch inside the visible region.
      g_col = 25;
      g_row = 8;
      goto(25, 8);
      tick();
      chk("glitch_h_err", h_err, 1);
      chk("glitch_v_err", v_err, 0);
      chk("glitch_locked", locked, 0);
      chk("glitch_pix_valid", pix_valid, 0);
      chk("glitch_fc_clear", frame_count, 0);
      g_col = -1;
      tick();
      chk("glitch_h_err_pulse", h_err, 0);
      wait_lock("relock_after_glitch");

      // VSYNC stuck high: the missing fall is caught at row VSS, col 0.
      goto(0, 5);
      vs_hold = 1'b1;
      cnt_verr = 0;
      goto(0, VSS);
      tick();
      chk("vhold_v_err", v_err, 1);
      chk("vhold_h_err", h_err, 0);
      chk("vhold_locked", locked, 0);
      chk("vhold_v_err_count", cnt_verr, 1);
      vs_hold = 1'b0;
      wait_lock("relock_after_vhold");

      // One-cycle reset in the middle of the visible area.
      goto(0, 0);
      goto(20, 10);
      chk("pre_rst_locked", locked, 1);
      chk("pre_rst_fc", frame_count, 1);
      chk("pre_rst_valid", pix_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_pix_valid", pix_valid, 0);
      chk("midrst_pix_x", pix_x, 0);
      chk("midrst_pix_y", pix_y, 0);
      chk("midrst_pix_rgb", pix_rgb, 0);
      chk("midrst_locked", locked, 0);
      chk("midrst_fc", frame_count, 0);
      chk("midrst_frame_done", frame_done, 0);
      wait_lock("relock_after_rst");

      // Line length one clock too long must never acquire.
      rst = 1'b1;
      drv_hold = 1'b1;
      cur_col = 0;
      cur_row = 0;
      drv_htot = HT + 1;
      drive();
      repeat (3) tick();
      rst = 1'b0;
      drv_hold = 1'b0;
      clr_counts();
      repeat (2 * (HT + 1) * VT + 100) tick();
      chk("badh_locked", cnt_locked, 0);
      chk("badh_pix_valid", cnt_valid, 0);
      chk("badh_h_err", cnt_herr, 0);
      chk("badh_v_err", cnt_verr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
